// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read/write/issue ports from decode, read data and hazard status back.
interface regfile_mp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] SrcReg;
  logic [NUM_RD*DATA_W-1:0] SrcData;
  logic [NUM_RD-1:0]        SrcPending;
  logic [NUM_WR-1:0]        WriteReg;
  logic [NUM_WR*ADDR_W-1:0] DstReg;
  logic [NUM_WR*DATA_W-1:0] DstData;
  logic                     IssueEn;
  logic [ADDR_W-1:0]        IssueReg;
  logic [ADDR_W:0]          PendCnt;

  modport master (
    output SrcReg, WriteReg, DstReg, DstData, IssueEn, IssueReg,
    input  SrcData, SrcPending, PendCnt
  );

  modport slave (
    input  SrcReg, WriteReg, DstReg, DstData, IssueEn, IssueReg,
    output SrcData, SrcPending, PendCnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-before-read bypass and a per-register pending scoreboard.
// Reads are combinational (0 cycles); writes/issues land on the next edge; no backpressure.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs [NREGS];
  logic [NREGS-1:0]         pend;
  logic [NREGS-1:0]         pend_nxt;
  logic [ADDR_W:0]          cnt;
  logic [ADDR_W:0]          cnt_nxt;
  logic [NUM_RD*DATA_W-1:0] src_data;
  logic [NUM_RD-1:0]        src_pend;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_hit;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Clears are applied before the issue so a same-cycle issue supersedes the write.
  always_comb begin
    pend_nxt = pend;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.WriteReg[w]) begin
        pend_nxt[bus.DstReg[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (bus.IssueEn && !is_zero(bus.IssueReg)) begin
      pend_nxt[bus.IssueReg] = 1'b1;
    end
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
      cnt  <= '0;
    end else begin
      // Later ports overwrite earlier ones, giving the highest index priority.
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.WriteReg[w] && !is_zero(bus.DstReg[w*ADDR_W +: ADDR_W])) begin
          regs[bus.DstReg[w*ADDR_W +: ADDR_W]] <= bus.DstData[w*DATA_W +: DATA_W];
        end
      end
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    src_data = '0;
    src_pend = '0;
    rd_addr  = '0;
    rd_data  = '0;
    rd_hit   = 1'b0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_addr = bus.SrcReg[r*ADDR_W +: ADDR_W];
      rd_data = regs[rd_addr];
      rd_hit  = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.WriteReg[w] && (bus.DstReg[w*ADDR_W +: ADDR_W] == rd_addr) &&
            !rst && !is_zero(rd_addr)) begin
          rd_hit  = 1'b1;
          rd_data = bus.DstData[w*DATA_W +: DATA_W];
        end
      end
      if (is_zero(rd_addr)) begin
        rd_data = '0;
      end
      src_data[r*DATA_W +: DATA_W] = rd_data;
      src_pend[r] = pend[rd_addr] && !rd_hit && !rst;
    end
  end

  assign bus.SrcData    = src_data;
  assign bus.SrcPending = src_pend;
  assign bus.PendCnt    = cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued as stimulus is driven and popped at each check.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;
  sb_item_t sb[$];

  regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_item_t it;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=queued_value", obs);
    end
    if (sb.size() != 0) begin
      it = sb.pop_front();
      assert (obs === it.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic idle();
    bus.WriteReg = '0;
    bus.DstReg   = '0;
    bus.DstData  = '0;
    bus.IssueEn  = 1'b0;
    bus.IssueReg = '0;
  endtask

  task automatic wr(input int w, input logic [3:0] a, input logic [15:0] d);
    bus.WriteReg[w]       = 1'b1;
    bus.DstReg[w*4 +: 4]  = a;
    bus.DstData[w*16 +: 16] = d;
  endtask

  task automatic rd(input int r, input logic [3:0] a);
    bus.SrcReg[r*4 +: 4] = a;
  endtask

  task automatic issue(input logic [3:0] a);
    bus.IssueEn  = 1'b1;
    bus.IssueReg = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] rdata(input int r);
    return {16'h0, bus.SrcData[r*16 +: 16]};
  endfunction

  function automatic logic [31:0] rpend(input int r);
    return {31'h0, bus.SrcPending[r]};
  endfunction

  function automatic logic [31:0] pcnt();
    return {27'h0, bus.PendCnt};
  endfunction

  initial begin
    idle();
    bus.SrcReg = '0;
    rst = 1'b1;
    tick();

    // Reset held: write/issue must neither bypass nor land.
    wr(0, 4'd2, 16'hABCD);
    issue(4'd2);
    rd(0, 4'd2);
    settle();
    push("rst_no_bypass", 32'h0);   chk(rdata(0));
    push("rst_no_pending", 32'h0);  chk(rpend(0));
    tick();
    rst = 1'b0;
    idle();
    for (int a = 0; a < 16; a++) begin
      rd(0, 4'(a));
      rd(1, 4'(15 - a));
      settle();
      push($sformatf("reset_data0_r%0d", a), 32'h0); chk(rdata(0));
      push($sformatf("reset_data1_r%0d", 15 - a), 32'h0); chk(rdata(1));
      push($sformatf("reset_pend0_r%0d", a), 32'h0); chk(rpend(0));
    end
    push("reset_pendcnt", 32'h0); chk(pcnt());

    // Write on both ports with same-cycle bypass, then stored value.
    wr(0, 4'd2, 16'hABCD);
    wr(1, 4'd5, 16'h1234);
    rd(0, 4'd2);
    rd(1, 4'd5);
    settle();
    push("bypass_p0_r2", 32'hABCD); chk(rdata(0));
    push("bypass_p1_r5", 32'h1234); chk(rdata(1));
    tick();
    idle();
    settle();
    push("stored_r2", 32'hABCD); chk(rdata(0));
    push("stored_r5", 32'h1234); chk(rdata(1));

    // Same address on both ports: port 1 wins.
    wr(0, 4'd3, 16'h1111);
    wr(1, 4'd3, 16'h2222);
    rd(0, 4'd3);
    settle();
    push("prio_bypass_r3", 32'h2222); chk(rdata(0));
    tick();
    idle();
    settle();
    push("prio_stored_r3", 32'h2222); chk(rdata(0));

    // Zero register ignores writes.
    wr(0, 4'd0, 16'hFFFF);
    rd(0, 4'd0);
    settle();
    push("zero_bypass", 32'h0); chk(rdata(0));
    tick();
    idle();
    settle();
    push("zero_stored", 32'h0); chk(rdata(0));

    // Issue then write clears pending.
    issue(4'd7);
    tick();
    idle();
    rd(0, 4'd7);
    settle();
    push("issue_pend_r7", 32'h1); chk(rpend(0));
    push("issue_cnt", 32'h1);     chk(pcnt());
    wr(1, 4'd7, 16'h7777);
    settle();
    push("write_hit_pend_r7", 32'h0);    chk(rpend(0));
    push("write_hit_data_r7", 32'h7777); chk(rdata(0));
    tick();
    idle();
    settle();
    push("cleared_cnt", 32'h0);    chk(pcnt());
    push("cleared_pend_r7", 32'h0); chk(rpend(0));

    // Same-cycle issue and write: set wins.
    issue(4'd4);
    wr(0, 4'd4, 16'h4444);
    tick();
    idle();
    rd(0, 4'd4);
    settle();
    push("setwins_pend_r4", 32'h1);    chk(rpend(0));
    push("setwins_cnt", 32'h1);        chk(pcnt());
    push("setwins_data_r4", 32'h4444); chk(rdata(0));
    issue(4'd0);
    tick();
    idle();
    settle();
    push("issue_zero_cnt", 32'h1); chk(pcnt());
    issue(4'd4);
    tick();
    idle();
    settle();
    push("reissue_cnt", 32'h1); chk(pcnt());

    // Fill: write and issue every non-zero register.
    for (int i = 1; i < 16; i++) begin
      wr(0, 4'(i), 16'h1000 + 16'(i));
      issue(4'(i));
      tick();
      idle();
    end
    rd(0, 4'd9);
    rd(1, 4'd15);
    settle();
    push("full_cnt", 32'd15);        chk(pcnt());
    push("full_data_r9", 32'h1009);  chk(rdata(0));
    push("full_data_r15", 32'h100F); chk(rdata(1));
    push("full_pend_r9", 32'h1);     chk(rpend(0));
    issue(4'd3);
    tick();
    idle();
    settle();
    push("full_nowrap_cnt", 32'd15); chk(pcnt());
    wr(0, 4'd1, 16'hAAAA);
    wr(1, 4'd2, 16'hBBBB);
    tick();
    idle();
    settle();
    push("two_clears_cnt", 32'd13); chk(pcnt());
    wr(0, 4'd3, 16'hCCCC);
    wr(1, 4'd3, 16'hDDDD);
    tick();
    idle();
    settle();
    push("dup_clear_cnt", 32'd12); chk(pcnt());

    // Mid-sequence reset discards the in-flight write and issue.
    rst = 1'b1;
    wr(0, 4'd9, 16'hDEAD);
    issue(4'd1);
    tick();
    rst = 1'b0;
    idle();
    for (int a = 0; a < 16; a++) begin
      rd(0, 4'(a));
      settle();
      push($sformatf("midrst_data_r%0d", a), 32'h0); chk(rdata(0));
      push($sformatf("midrst_pend_r%0d", a), 32'h0); chk(rpend(0));
    end
    push("midrst_cnt", 32'h0); chk(pcnt());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
